// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch-stage PC sequencer.
package pc_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} pc_state_t;
   localparam int CNT_W = 16;
   localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;
endpackage

// File: rtl/pc_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; 1-cycle update latency.
// No backpressure: en simply gates the increment, clear wins over enable.
module sat_counter
   import pc_pkg::*;
(
   input  logic             Clk,
   input  logic             Reset,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] cnt
);

   always_ff @(posedge Clk) begin
      if (Reset || clr) begin
         cnt <= '0;
      end else if (en && (cnt != CNT_MAX)) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: IDLE/RUN/DONE walk with LUT-resolved branches, 1-cycle PC update.
// stall holds PC and count; branch targets are absolute unless PC_REL_JUMP_EN selects PC-relative.
module pc_sequencer
   import pc_pkg::*;
#(
   parameter int             D          = 10,
   parameter int             LUT_AW     = 4,
   parameter logic [D-1:0]   START_ADDR = '0
)
(
   input  logic              Clk,
   input  logic              Reset,
   input  logic              start,
   input  logic              stall,
   input  logic              halt,
   input  logic              branch_en,
   input  logic [LUT_AW-1:0] lut_idx,
   output logic [LUT_AW-1:0] lut_addr,
   input  logic [D-1:0]      lut_target,
   output logic [D-1:0]      prog_ctr,
   output logic              running,
   output logic              done,
   output logic [15:0]       instr_cnt
);

   pc_state_t    state;
   logic [D-1:0] branch_tgt;
   logic         cnt_clr;
   logic         cnt_en;

   assign lut_addr = lut_idx;

`ifdef PC_REL_JUMP_EN
   // Two's-complement offset: plain modular add gives the signed result.
   assign branch_tgt = prog_ctr + lut_target;
`else
   assign branch_tgt = lut_target;
`endif

   assign cnt_clr = start && (state != RUN);
   assign cnt_en  = (state == RUN) && !stall;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state    <= IDLE;
         prog_ctr <= '0;
         running  <= 1'b0;
         done     <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state    <= RUN;
                  prog_ctr <= START_ADDR;
                  running  <= 1'b1;
                  done     <= 1'b0;
               end
            end
            RUN: begin
               if (!stall) begin
                  if (halt) begin
                     state   <= DONE;
                     running <= 1'b0;
                     done    <= 1'b1;
                  end else if (branch_en) begin
                     prog_ctr <= branch_tgt;
                  end else begin
                     prog_ctr <= prog_ctr + D'(1);
                  end
               end
            end
            default: begin
               state    <= IDLE;
               prog_ctr <= '0;
               running  <= 1'b0;
               done     <= 1'b0;
            end
         endcase
      end
   end

   sat_counter u_instr_cnt (
      .Clk   (Clk),
      .Reset (Reset),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .cnt   (instr_cnt)
   );

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus randomized bench for pc_sequencer against a behavioural model.
module tb_pc_sequencer;

   localparam int D = 10;
   localparam int LUT_AW = 4;

   logic              Clk = 1'b0;
   logic              Reset;
   logic              start;
   logic              stall;
   logic              halt;
   logic              branch_en;
   logic [LUT_AW-1:0] lut_idx;
   logic [LUT_AW-1:0] lut_addr;
   logic [D-1:0]      lut_target;
   logic [D-1:0]      prog_ctr;
   logic              running;
   logic              done;
   logic [15:0]       instr_cnt;

   logic [D-1:0] lut [16];
   assign lut_target = lut[lut_addr];

   always #5 Clk = ~Clk;

   pc_sequencer #(.D(D), .LUT_AW(LUT_AW), .START_ADDR('0)) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .start      (start),
      .stall      (stall),
      .halt       (halt),
      .branch_en  (branch_en),
      .lut_idx    (lut_idx),
      .lut_addr   (lut_addr),
      .lut_target (lut_target),
      .prog_ctr   (prog_ctr),
      .running    (running),
      .done       (done),
      .instr_cnt  (instr_cnt)
   );

   // Model: mode 0 = idle, 1 = running, 2 = finished.
   int m_mode = 0;
   int m_pc   = 0;
   int m_cnt  = 0;

   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string tag, input int got, input int exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic retire();
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
   endtask

   // One clock: drive inputs, advance the model, optionally compare outputs.
   task automatic step(input bit rst, input bit st, input bit sl, input bit hl,
                       input bit br, input int idx, input bit chk);
      @(negedge Clk);
      Reset     = rst;
      start     = st;
      stall     = sl;
      halt      = hl;
      branch_en = br;
      lut_idx   = LUT_AW'(idx);
      #1;
      if (chk) check("lut_addr", int'(lut_addr), idx);
      if (rst) begin
         m_mode = 0; m_pc = 0; m_cnt = 0;
      end else if (m_mode != 1) begin
         if (st) begin m_mode = 1; m_pc = 0; m_cnt = 0; end
      end else if (!sl) begin
         if (hl) begin
            m_mode = 2;
            retire();
         end else if (br) begin
`ifdef PC_REL_JUMP_EN
            m_pc = (m_pc + int'(lut[idx])) % 1024;
`else
            m_pc = int'(lut[idx]);
`endif
            retire();
         end else begin
            m_pc = (m_pc + 1) % 1024;
            retire();
         end
      end
      @(posedge Clk);
      #1;
      if (chk) begin
         check("prog_ctr", int'(prog_ctr), m_pc);
         check("instr_cnt", int'(instr_cnt), m_cnt);
         check("running", int'(running), int'(m_mode == 1));
         check("done", int'(done), int'(m_mode == 2));
      end
   endtask

   task automatic plain(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 1);
   endtask

   initial begin
      Reset = 1'b1; start = 1'b0; stall = 1'b0; halt = 1'b0;
      branch_en = 1'b0; lut_idx = '0;
      for (int i = 0; i < 16; i++) lut[i] = D'($urandom);

      // Reset, start, three plain steps
      step(1, 0, 0, 0, 0, 0, 1);
      step(1, 1, 0, 0, 0, 0, 1);
      step(0, 1, 0, 0, 0, 0, 1);
      check("start_pc", int'(prog_ctr), 0);
      plain(3);
      check("pc_after3", int'(prog_ctr), 3);
      check("cnt_after3", int'(instr_cnt), 3);
      step(0, 1, 0, 0, 0, 0, 1);            // start during RUN ignored
      check("pc_at4", int'(prog_ctr), 4);

      // Branch from PC=4 with target 20
      lut[5] = 10'd20;
      step(0, 0, 0, 0, 1, 5, 1);
`ifdef PC_REL_JUMP_EN
      check("br_rel20", int'(prog_ctr), 24);
`else
      check("br_abs20", int'(prog_ctr), 20);
`endif

      // Restart and walk to PC=4 again
      step(0, 0, 0, 1, 0, 0, 1);
      step(0, 1, 0, 0, 0, 0, 1);
      plain(4);
`ifdef PC_REL_JUMP_EN
      lut[1] = 10'h3FF;
      step(0, 0, 0, 0, 1, 1, 1);
      check("br_minus1", int'(prog_ctr), 3);
      plain(1);
      lut[2] = 10'h3FB;
      step(0, 0, 0, 0, 1, 2, 1);
      check("br_minus5", int'(prog_ctr), 10'h3FF);
`else
      lut[3] = 10'h3FF;
      step(0, 0, 0, 0, 1, 3, 1);
      check("br_abs3ff", int'(prog_ctr), 10'h3FF);
`endif
      plain(1);
      check("pc_wrap", int'(prog_ctr), 0);

      // Stall masks halt and branch
      step(0, 0, 1, 1, 1, 5, 1);
      step(0, 0, 1, 1, 1, 5, 1);
      check("stall_pc", int'(prog_ctr), 0);
      check("stall_run", int'(running), 1);

      // Halt at PC=7, hold, restart
      plain(7);
      step(0, 0, 0, 1, 0, 0, 1);
      check("halt_done", int'(done), 1);
      check("halt_pc", int'(prog_ctr), 7);
      step(0, 0, 0, 0, 1, 5, 1);
      step(0, 0, 0, 1, 0, 0, 1);
      step(0, 1, 0, 0, 0, 0, 1);
      check("restart_cnt", int'(instr_cnt), 0);

      // Reset mid-RUN at PC=12
      plain(12);
      step(1, 0, 0, 0, 0, 0, 1);
      check("rst_mid_pc", int'(prog_ctr), 0);

      // Randomized phase
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 15) == 0) lut[$urandom_range(0, 15)] = D'($urandom);
         step($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0,
              $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
              $urandom_range(0, 3) == 0, int'($urandom_range(0, 15)), 1);
      end

      // Saturation: 70000 un-stalled cycles
      step(1, 0, 0, 0, 0, 0, 1);
      step(0, 1, 0, 0, 0, 0, 1);
      for (int i = 0; i < 70000; i++) step(0, 0, 0, 0, 0, 0, 0);
      check("cnt_sat", int'(instr_cnt), 16'hFFFF);
      check("sat_pc", int'(prog_ctr), 70000 % 1024);
      plain(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
